// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares a single synchronous-read SRAM (mem_unit) between two requesters:
//   port 0 (instruction fetch) and port 1 (load/store). Accepts one request
//   at a time, drives the memory port from registers, waits out the read
//   latency and returns a held response to the granted requester.
//
// Parameters
//   ADDR_W   memory word-address width
//   DATA_W   data word width
//   MEM_LAT  cycles from the mem_unit sampling edge to data_o valid (1..7)
//
// Ports
//   clk_i, rst_i                 clock (rising edge), async active-high reset
//   pN_req_valid_i/ready_o       request handshake, port N
//   pN_wr_i, pN_addr_i, pN_data_i request payload, port N
//   pN_rsp_valid_o/ready_i       response handshake, port N
//   pN_rsp_data_o                read data (0 for a write response), port N
//   mem_en_o, mem_wr_o,
//   mem_addr_o, mem_data_o       to mem_unit en_i / wr_i / addr_i / data_i
//   mem_data_i                   from mem_unit data_o
//   busy_o                       high whenever the FSM is not in IDLE
//
// Build option
//   MEM_ARB_RR_EN  defined: round-robin arbitration with a 1-bit preferred-
//                  port pointer. Undefined: fixed priority, port 1 wins.
//
// States
//   IDLE  | waiting for a request; req_ready_o driven for the winner
//   ISSUE | memory request presented, mem_unit samples it on exit
//   WAIT  | counting down the read latency, capture data on exit
//   RESP  | response held on the granted port until rsp_ready_i
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_req_valid_i,
    output logic              p0_req_ready_o,
    input  logic              p0_wr_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic              p0_rsp_valid_o,
    input  logic              p0_rsp_ready_i,
    output logic [DATA_W-1:0] p0_rsp_data_o,
    input  logic              p1_req_valid_i,
    output logic              p1_req_ready_o,
    input  logic              p1_wr_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic              p1_rsp_valid_o,
    input  logic              p1_rsp_ready_i,
    output logic [DATA_W-1:0] p1_rsp_data_o,
    output logic              mem_en_o,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              busy_o
);

    localparam int LAT_W = 3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q;
    logic              grant_q;      // 1 = port 1 owns the current access
    logic              op_wr_q;      // current access is a write
    logic [LAT_W-1:0]  lat_q;
    logic              mem_en_q;
    logic              mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;
    logic              p0_rsp_valid_q;
    logic              p1_rsp_valid_q;
    logic [DATA_W-1:0] p0_rsp_data_q;
    logic [DATA_W-1:0] p1_rsp_data_q;

    logic              grant_d;      // arbitration winner this cycle
    logic              any_req;
    logic              rsp_ready;

`ifdef MEM_ARB_RR_EN
    logic              rr_q;         // preferred port when both request

    always_comb begin
        grant_d = p1_req_valid_i;
        if (p0_req_valid_i && p1_req_valid_i) begin
            grant_d = rr_q;
        end
    end
`else
    // Port 1 wins whenever it is requesting; port 0 only when alone.
    assign grant_d = p1_req_valid_i;
`endif

    assign any_req        = p0_req_valid_i | p1_req_valid_i;
    assign p0_req_ready_o = (state_q == IDLE) && p0_req_valid_i && !grant_d;
    assign p1_req_ready_o = (state_q == IDLE) && p1_req_valid_i && grant_d;
    assign rsp_ready      = grant_q ? p1_rsp_ready_i : p0_rsp_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            grant_q        <= 1'b0;
            op_wr_q        <= 1'b0;
            lat_q          <= '0;
            mem_en_q       <= 1'b0;
            mem_wr_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_q     <= '0;
            p0_rsp_valid_q <= 1'b0;
            p1_rsp_valid_q <= 1'b0;
            p0_rsp_data_q  <= '0;
            p1_rsp_data_q  <= '0;
`ifdef MEM_ARB_RR_EN
            rr_q           <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        mem_en_q   <= 1'b1;
                        mem_wr_q   <= grant_d ? p1_wr_i : p0_wr_i;
                        op_wr_q    <= grant_d ? p1_wr_i : p0_wr_i;
                        mem_addr_q <= grant_d ? p1_addr_i : p0_addr_i;
                        mem_data_q <= grant_d ? p1_data_i : p0_data_i;
                        grant_q    <= grant_d;
`ifdef MEM_ARB_RR_EN
                        rr_q       <= ~grant_d;
`endif
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // addr/data stay put; only the strobes drop
                    mem_en_q <= 1'b0;
                    mem_wr_q <= 1'b0;
                    lat_q    <= LAT_W'(MEM_LAT - 1);
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (lat_q == '0) begin
                        if (grant_q) begin
                            p1_rsp_data_q  <= op_wr_q ? '0 : mem_data_i;
                            p1_rsp_valid_q <= 1'b1;
                        end else begin
                            p0_rsp_data_q  <= op_wr_q ? '0 : mem_data_i;
                            p0_rsp_valid_q <= 1'b1;
                        end
                        state_q <= RESP;
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        p0_rsp_valid_q <= 1'b0;
                        p1_rsp_valid_q <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_en_o       = mem_en_q;
    assign mem_wr_o       = mem_wr_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_data_o     = mem_data_q;
    assign p0_rsp_valid_o = p0_rsp_valid_q;
    assign p1_rsp_valid_o = p1_rsp_valid_q;
    assign p0_rsp_data_o  = p0_rsp_data_q;
    assign p1_rsp_data_o  = p1_rsp_data_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one mem_unit instance (synchronous-read SRAM: en_i, wr_i, addr_i, data_i, data_o) between two requesters: port 0 (instruction fetch) and port 1 (load/store).
- Accepts one request at a time over a valid/ready handshake and drives the memory port from registers.
- Waits out the memory read latency, then returns a held response to the granted requester.
- Sits between the fetch/LSU stages and mem_unit in the uarch simulator.

Parameters:
ADDR_W, 11, memory word-address width
DATA_W, 32, data word width
MEM_LAT, 1, cycles from the mem_unit sampling edge to data_o valid; legal range 1..7

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
p0_req_valid_i  in  1  port 0 request valid
p0_req_ready_o  out  1  port 0 request accepted this cycle
p0_wr_i  in  1  port 0 write (1) / read (0)
p0_addr_i  in  ADDR_W  port 0 address
p0_data_i  in  DATA_W  port 0 write data
p0_rsp_valid_o  out  1  port 0 response valid
p0_rsp_ready_i  in  1  port 0 response consumed
p0_rsp_data_o  out  DATA_W  port 0 read data
p1_req_valid_i, p1_req_ready_o, p1_wr_i, p1_addr_i, p1_data_i, p1_rsp_valid_o, p1_rsp_ready_i, p1_rsp_data_o: same widths and meaning, port 1
mem_en_o  out  1  to mem_unit en_i
mem_wr_o  out  1  to mem_unit wr_i
mem_addr_o  out  ADDR_W  to mem_unit addr_i
mem_data_o  out  DATA_W  to mem_unit data_i
mem_data_i  in  DATA_W  from mem_unit data_o
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset state and outputs: rst_i high forces state IDLE. All registered outputs go to 0: mem_*_o, rsp_valid, rsp_data, lat counter, grant, rr pointer. Reset applies at any time, including mid-access; an in-flight request is dropped, with no response issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready_o is combinational and goes high only for the arbitration winner whose req_valid_i is high.
  - Handshake completes on an edge with valid && ready. On that edge, latch wr/addr/data into mem_*_o, set mem_en_o=1, record grant, and move to ISSUE.
  - Both req_ready_o are always 0 outside IDLE.
- Arbitration (default build): fixed priority, port 1 over port 0. Port 0 may starve.
- ISSUE: lasts one cycle; mem_unit samples the request on the exiting edge. On that edge, mem_en_o goes to 0 (mem_wr_o also to 0), lat counter loads MEM_LAT-1, and state moves to WAIT.
- WAIT:
  - For a read: when the counter is 0, capture mem_data_i into the granted port's rsp_data on that edge and move to RESP; otherwise decrement.
  - For a write: skip the capture, set rsp_data to 0, and move to RESP on the same counter rule.
- RESP: the granted port's rsp_valid_o is 1; the other port's is 0. Hold rsp_valid_o and rsp_data_o stable until rsp_ready_i is high at an edge, then clear rsp_valid_o and return to IDLE.
- Latency: with the accept at edge N, rsp_valid_o rises after edge N+1+MEM_LAT. Throughput is one access per MEM_LAT+3 cycles when rsp_ready_i is held high.
- Non-granted port: rsp_data_o holds its last value and rsp_valid_o stays 0.
- Requester rule: req payload only needs to be stable in the accept cycle, because it is latched.
- mem_addr_o and mem_data_o keep their last values while mem_en_o=0.
- req_valid_i dropped before acceptance is legal and has no effect.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit pointer names the preferred port.
  - When both ports are valid in IDLE, the preferred port wins.
  - After each accept, the pointer flips to the port that was not granted.
  - With only one port valid, that port wins and the pointer still updates.
  - The pointer resets to port 0.
- Undefined: fixed priority, port 1 wins; no pointer logic.

Test Plan:
1. Port 1 write addr 0x003 data 0xFF, then read 0x003, MEM_LAT=1 -> write response rsp_data=0; read rsp_valid rises 2 cycles after the accept edge with rsp_data=0x000000FF; mem_en_o high exactly one cycle per access.
2. Both ports request reads on the same cycle, default build -> port 1 granted first and port 0 second; p0_req_ready_o stays 0 until the FSM returns to IDLE.
3. MEM_ARB_RR_EN defined, both ports hold valid for 4 accesses -> grant order 0,1,0,1.
4. Port 0 read with p0_rsp_ready_i held low for 5 cycles -> p0_rsp_valid_o and p0_rsp_data_o stay stable; busy_o=1 throughout; returns to IDLE on the edge after rsp_ready_i rises.
5. MEM_LAT=3 read -> capture occurs 3 edges after the ISSUE-exit edge; data correct.
6. rst_i asserted mid-WAIT (asynchronously, between clock edges) -> mem_en_o, rsp_valid_o and busy_o go to 0 immediately, no response is produced, and a new request is accepted normally after reset.
